mipi_rx_frame_decoder: RTL and testbench
========================================

Name: mipi_rx_frame_decoder

Overview:
Receive-side counterpart of the MIPI TX video path. Sits directly behind the Efinix MIPI RX hard block parallel interface, in the rx_pixel_clk domain. Filters beats by virtual channel and data type, converts HSYNC/VSYNC levels into a framed pixel stream with SOF/EOL markers, and measures per-frame HRES/VRES and framing errors. Output feeds the loopback checker and the frame buffer writer.

Parameters:
DATA_W, 64, RX data bus width (bits)
CNT_W, 4, width of RX per-beat valid-pixel count
MEAS_W, 16, width of resolution and frame counters

Ports:
rx_pixel_clk  in  1  sole clock
rst_n  in  1  asynchronous, active-low reset
mipi_rx_DATA  in  DATA_W  RX beat data
mipi_rx_VALID  in  1  RX beat valid
mipi_rx_CNT  in  CNT_W  valid pixels in beat
mipi_rx_HSYNC  in  4  per-VC line-active level
mipi_rx_VSYNC  in  4  per-VC frame-active level
mipi_rx_VC  in  2  VC of current beat
mipi_rx_TYPE  in  6  CSI-2 data type of current beat
cfg_vc  in  2  selected VC (sample only in IDLE)
cfg_type  in  6  accepted data type, e.g. 0x24 RGB888 (sample only in IDLE)
err_clr  in  1  clears sticky error flags
pix_data  out  DATA_W  output beat
pix_cnt  out  CNT_W  pixels in output beat
pix_valid  out  1  output beat valid
pix_sof  out  1  first beat of frame (qualified by pix_valid)
pix_eol  out  1  last beat of line (qualified by pix_valid)
meas_hres  out  MEAS_W  pixels in last line of last frame
meas_vres  out  MEAS_W  lines in last frame
meas_valid  out  1  one-cycle pulse when meas_* update
frame_count  out  MEAS_W  completed frames, wraps at 2^MEAS_W
err_hres  out  1  sticky: line lengths in a frame differ
err_trunc  out  1  sticky: VSYNC fell while a line was open
err_type  out  1  sticky: beat with selected VC and wrong TYPE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; hold register empty.
- vs = mipi_rx_VSYNC[cfg_vc_q], hs = mipi_rx_HSYNC[cfg_vc_q]. Edges are taken against a 1-cycle registered copy.
- Accepted beat: VALID=1, VC=cfg_vc_q and TYPE=cfg_type_q. VALID with matching VC but TYPE mismatch sets err_type; the beat is dropped. Beats on other VCs are ignored silently.
- FSM:
  - IDLE: latch cfg_vc_q/cfg_type_q. On vs rise go to FRAME; clear line counter, hres reference and first-beat flag.
  - FRAME: on hs rise go to LINE; clear the pixel counter.
  - LINE: accepted beats add CNT to the pixel counter, saturating at all-ones. On hs fall go to FRAME and increment the line counter (saturating).
  - Any state except IDLE, on vs fall: go to IDLE, update meas_*, pulse meas_valid, increment frame_count.
- One-beat hold buffer in LINE:
  - An accepted beat is stored in the hold register.
  - The previous held beat is emitted in the same cycle with pix_eol=0.
  - On hs fall, the held beat is emitted with pix_eol=1.
  - Latency: one beat, or flush on the hs-fall cycle.
  - An accepted beat in the same cycle as hs fall is appended first; that beat is the one emitted with EOL, and the previously held beat is dropped into the same slot. Implementation must not lose data here: the hold register emits its beat, and the new beat emits with EOL on the next cycle.
- pix_sof=1 on the first emitted beat after vs rise.
- Line close with a zero-pixel line: no beat is emitted, and the line still counts.
- Line-length check: the first closed line sets hres_ref. Any later closed line with a different count sets err_hres. meas_hres is the last closed line's count.
- vs fall while in LINE:
  - Flush the held beat with EOL.
  - Set err_trunc.
  - Do not count the partial line.
- vs rise while not in IDLE: treat as frame end followed by frame start (meas update, then restart).
- err_clr clears sticky errors. If an error event occurs in the same cycle as err_clr, the event wins.
- Mid-frame async reset returns everything to reset values, with no partial measurement output.

Decomposition:
- Package mipi_rx_pkg: FSM state enum (IDLE, FRAME, LINE); CSI-2 data-type constants (RAW8 0x2A, RAW10 0x2B, RGB888 0x24, YUV422_8 0x1E).
- One natural sub-module: mipi_rx_line_buf, the one-beat hold/flush stage with the EOL collision handling.

Test Plan:
- VC0 RGB888 frame, 4 lines × 3 beats of CNT=8 → 12 beats out; SOF on beat 0; EOL on beats 2, 5, 8, 11; meas_hres=24, meas_vres=4, frame_count=1, no errors.
- Line 2 has 2 beats (16 px), others 24 → err_hres=1 after frame; meas_hres equals last line length (24); err_clr → 0.
- vs falls mid-line 3 after 1 beat → that beat emitted with EOL; err_trunc=1; meas_vres=2.
- cfg_vc=1 while VC0 traffic is interleaved → only VC1 beats emitted; VC0 beats with wrong TYPE do not set err_type.
- Selected-VC beat with TYPE 0x2A while cfg_type=0x24 → beat dropped, err_type=1, pixel count unchanged.
- Accepted beat coincident with hs fall, then rst_n pulsed low mid-next-frame → no beat lost and last beat carries EOL; after reset all outputs 0, next full frame measures correctly.

Source files
------------

// File: rtl/mipi_rx_pkg.sv
// mipi_rx_pkg: shared FSM state and CSI-2 data-type codes for the MIPI RX frame decoder
package mipi_rx_pkg;
  typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_RGB888   = 6'h24;
  localparam logic [5:0] DT_YUV422_8 = 6'h1E;
endpackage

// File: rtl/mipi_rx_line_buf.sv
// mipi_rx_line_buf: one-beat hold stage that tags the last beat of each line with EOL
module mipi_rx_line_buf #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              close,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_cnt,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol
);
  logic              h_v, h_eol, first, emit;
  logic [DATA_W-1:0] h_d;
  logic [CNT_W-1:0]  h_c;
  // a beat arriving together with close stays held one more cycle and leaves with EOL
  assign emit = h_v & (in_valid | close | h_eol);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      h_v       <= 1'b0;
      h_eol     <= 1'b0;
      h_d       <= '0;
      h_c       <= '0;
      first     <= 1'b0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit & first;
      out_eol   <= emit & (h_eol | (close & ~in_valid));
      if (emit) begin
        out_data <= h_d;
        out_cnt  <= h_c;
      end
      first <= start | (first & ~emit);
      h_v   <= in_valid | (h_v & ~emit);
      h_eol <= in_valid & close;
      if (in_valid) begin
        h_d <= in_data;
        h_c <= in_cnt;
      end
    end
endmodule

// File: rtl/mipi_rx_frame_decoder.sv
// mipi_rx_frame_decoder: filters MIPI RX beats by VC/type, frames them with SOF/EOL
// and measures per-frame resolution and framing errors
module mipi_rx_frame_decoder
  import mipi_rx_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 4,
  parameter int MEAS_W = 16
) (
  input  logic              rx_pixel_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mipi_rx_DATA,
  input  logic              mipi_rx_VALID,
  input  logic [CNT_W-1:0]  mipi_rx_CNT,
  input  logic [3:0]        mipi_rx_HSYNC,
  input  logic [3:0]        mipi_rx_VSYNC,
  input  logic [1:0]        mipi_rx_VC,
  input  logic [5:0]        mipi_rx_TYPE,
  input  logic [1:0]        cfg_vc,
  input  logic [5:0]        cfg_type,
  input  logic              err_clr,
  output logic [DATA_W-1:0] pix_data,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic              pix_valid,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [MEAS_W-1:0] meas_hres,
  output logic [MEAS_W-1:0] meas_vres,
  output logic              meas_valid,
  output logic [MEAS_W-1:0] frame_count,
  output logic              err_hres,
  output logic              err_trunc,
  output logic              err_type
);
  state_t            state, state_nx;
  logic [1:0]        cfg_vc_q;
  logic [5:0]        cfg_type_q;
  logic              vs, hs, vs_q, hs_q, vs_rise, vs_fall, hs_rise, hs_fall;
  logic              sel, accept, type_bad, frame_end, trunc, line_close, ref_v;
  logic [MEAS_W-1:0] pix_acc, pix_nx, line_cnt, hres_ref, last_hres;
  logic [MEAS_W:0]   pix_sum;
  assign vs         = mipi_rx_VSYNC[cfg_vc_q];
  assign hs         = mipi_rx_HSYNC[cfg_vc_q];
  assign vs_rise    = vs & ~vs_q;
  assign vs_fall    = ~vs & vs_q;
  assign hs_rise    = hs & ~hs_q;
  assign hs_fall    = ~hs & hs_q;
  assign sel        = mipi_rx_VALID & (mipi_rx_VC == cfg_vc_q);
  assign accept     = sel & (mipi_rx_TYPE == cfg_type_q) & (state == LINE);
  assign type_bad   = sel & (mipi_rx_TYPE != cfg_type_q);
  assign frame_end  = (state != IDLE) & (vs_rise | vs_fall);
  assign trunc      = frame_end & (state == LINE);
  assign line_close = (state == LINE) & hs_fall & ~frame_end;
  assign pix_sum    = {1'b0, pix_acc} + (MEAS_W+1)'(mipi_rx_CNT);
  // the beat accepted on the closing cycle still belongs to the line being closed
  assign pix_nx     = accept ? (pix_sum[MEAS_W] ? '1 : pix_sum[MEAS_W-1:0]) : pix_acc;
  always_comb begin
    state_nx = state;
    state_nx = (vs_fall && state != IDLE) ? IDLE :
               vs_rise                    ? FRAME :
               (state == FRAME && hs_rise) ? LINE :
               line_close                 ? FRAME : state;
  end
  always_ff @(posedge rx_pixel_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge rx_pixel_clk or negedge rst_n)
    if (!rst_n) begin
      cfg_vc_q    <= '0;
      cfg_type_q  <= '0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      pix_acc     <= '0;
      line_cnt    <= '0;
      hres_ref    <= '0;
      last_hres   <= '0;
      ref_v       <= 1'b0;
      meas_hres   <= '0;
      meas_vres   <= '0;
      meas_valid  <= 1'b0;
      frame_count <= '0;
      err_hres    <= 1'b0;
      err_trunc   <= 1'b0;
      err_type    <= 1'b0;
    end else begin
      vs_q <= vs;
      hs_q <= hs;
      if (state == IDLE) begin
        cfg_vc_q   <= cfg_vc;
        cfg_type_q <= cfg_type;
      end
      pix_acc <= (state == FRAME && hs_rise) ? '0 : pix_nx;
      meas_valid <= frame_end;
      if (frame_end) begin
        meas_hres   <= last_hres;
        meas_vres   <= line_cnt;
        frame_count <= frame_count + 1'b1;
      end
      if (vs_rise) begin
        line_cnt  <= '0;
        ref_v     <= 1'b0;
        hres_ref  <= '0;
        last_hres <= '0;
      end else if (line_close) begin
        line_cnt  <= (&line_cnt) ? line_cnt : line_cnt + 1'b1;
        last_hres <= pix_nx;
        ref_v     <= 1'b1;
        if (!ref_v) hres_ref <= pix_nx;
      end
      err_hres  <= (line_close & ref_v & (pix_nx != hres_ref)) | (err_hres & ~err_clr);
      err_trunc <= trunc | (err_trunc & ~err_clr);
      err_type  <= type_bad | (err_type & ~err_clr);
    end
  mipi_rx_line_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_line_buf (
    .clk      (rx_pixel_clk),
    .rst_n    (rst_n),
    .start    (vs_rise),
    .in_valid (accept),
    .close    ((state == LINE) & (hs_fall | frame_end)),
    .in_data  (mipi_rx_DATA),
    .in_cnt   (mipi_rx_CNT),
    .out_data (pix_data),
    .out_cnt  (pix_cnt),
    .out_valid(pix_valid),
    .out_sof  (pix_sof),
    .out_eol  (pix_eol)
  );
endmodule

// File: tb/tb_mipi_rx_frame_decoder.sv
// tb_mipi_rx_frame_decoder: directed frames with hand-computed beats, markers and measurements
module tb_mipi_rx_frame_decoder;
  import mipi_rx_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] mipi_rx_DATA;
  logic        mipi_rx_VALID;
  logic [3:0]  mipi_rx_CNT;
  logic [3:0]  mipi_rx_HSYNC, mipi_rx_VSYNC;
  logic [1:0]  mipi_rx_VC, cfg_vc;
  logic [5:0]  mipi_rx_TYPE, cfg_type;
  logic        err_clr;
  logic [63:0] pix_data;
  logic [3:0]  pix_cnt;
  logic        pix_valid, pix_sof, pix_eol, meas_valid, err_hres, err_trunc, err_type;
  logic [15:0] meas_hres, meas_vres, frame_count;
  int          total = 0, bad = 0, n_out = 0, n_mv = 0, base, mv0;
  logic [63:0] od[256];
  logic [3:0]  oc[256];
  logic        os[256], oe[256];
  logic [63:0] ed[$];
  bit          ee[$];
  always #5 clk = ~clk;
  mipi_rx_frame_decoder dut (
    .rx_pixel_clk(clk), .rst_n(rst_n), .mipi_rx_DATA(mipi_rx_DATA), .mipi_rx_VALID(mipi_rx_VALID),
    .mipi_rx_CNT(mipi_rx_CNT), .mipi_rx_HSYNC(mipi_rx_HSYNC), .mipi_rx_VSYNC(mipi_rx_VSYNC),
    .mipi_rx_VC(mipi_rx_VC), .mipi_rx_TYPE(mipi_rx_TYPE), .cfg_vc(cfg_vc), .cfg_type(cfg_type),
    .err_clr(err_clr), .pix_data(pix_data), .pix_cnt(pix_cnt), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .meas_hres(meas_hres), .meas_vres(meas_vres),
    .meas_valid(meas_valid), .frame_count(frame_count), .err_hres(err_hres),
    .err_trunc(err_trunc), .err_type(err_type)
  );
  always @(negedge clk) begin
    if (pix_valid && n_out < 256) begin
      od[n_out] <= pix_data;
      oc[n_out] <= pix_cnt;
      os[n_out] <= pix_sof;
      oe[n_out] <= pix_eol;
      n_out     <= n_out + 1;
    end
    if (meas_valid) n_mv <= n_mv + 1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [1:0] v, input logic [5:0] t, input logic [63:0] d);
    mipi_rx_VALID = 1'b1;
    mipi_rx_VC    = v;
    mipi_rx_TYPE  = t;
    mipi_rx_DATA  = d;
    mipi_rx_CNT   = 4'd8;
    tick;
    mipi_rx_VALID = 1'b0;
  endtask
  task automatic line(input logic [1:0] v, input int nb, input logic [63:0] d0);
    mipi_rx_HSYNC[v] = 1'b1;
    tick;
    for (int i = 0; i < nb; i++) beat(v, DT_RGB888, d0 + 64'(i));
    mipi_rx_HSYNC[v] = 1'b0;
    tick;
    tick;
  endtask
  task automatic vs_set(input logic [1:0] v, input logic l);
    mipi_rx_VSYNC[v] = l;
    tick;
    tick;
  endtask
  task automatic add_line(input int nb, input logic [63:0] d0);
    for (int i = 0; i < nb; i++) begin
      ed.push_back(d0 + 64'(i));
      ee.push_back(i == nb - 1);
    end
  endtask
  task automatic verify(input string tag);
    chk({tag, "_nbeats"}, 64'(n_out - base), 64'(ed.size()));
    for (int i = 0; i < ed.size() && base + i < 256; i++) begin
      chk($sformatf("%s_data%0d", tag, i), od[base+i], ed[i]);
      chk($sformatf("%s_cnt%0d", tag, i), 64'(oc[base+i]), 64'd8);
      chk($sformatf("%s_eol%0d", tag, i), 64'(oe[base+i]), 64'(ee[i]));
      chk($sformatf("%s_sof%0d", tag, i), 64'(os[base+i]), 64'(i == 0));
    end
  endtask
  task automatic start_frame(input logic [1:0] v);
    base = n_out;
    mv0  = n_mv;
    ed.delete();
    ee.delete();
    vs_set(v, 1'b1);
  endtask
  task automatic meas(input string tag, input int h, input int v, input int fc);
    chk({tag, "_hres"}, 64'(meas_hres), 64'(h));
    chk({tag, "_vres"}, 64'(meas_vres), 64'(v));
    chk({tag, "_fcount"}, 64'(frame_count), 64'(fc));
    chk({tag, "_mvpulse"}, 64'(n_mv - mv0), 64'd1);
  endtask
  task automatic clear_errs;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
  endtask
  initial begin
    {mipi_rx_DATA, mipi_rx_VALID, mipi_rx_CNT, mipi_rx_HSYNC, mipi_rx_VSYNC, mipi_rx_VC} = '0;
    mipi_rx_TYPE = DT_RGB888;
    cfg_vc = 2'd0;
    cfg_type = DT_RGB888;
    err_clr = 1'b0;
    tick;
    tick;
    chk("reset_outs", {pix_data[31:0], pix_cnt, pix_valid, pix_sof, pix_eol, meas_valid,
                       err_hres, err_trunc, err_type}, 64'd0);
    chk("reset_meas", {meas_hres, meas_vres, frame_count}, 64'd0);
    rst_n = 1'b1;
    tick;
    tick;
    start_frame(2'd0);
    for (int l = 0; l < 4; l++) begin
      line(2'd0, 3, 64'h100 + 64'(l * 16));
      add_line(3, 64'h100 + 64'(l * 16));
    end
    vs_set(2'd0, 1'b0);
    verify("f1");
    meas("f1", 24, 4, 1);
    chk("f1_errs", {err_hres, err_trunc, err_type}, 64'd0);
    start_frame(2'd0);
    for (int l = 0; l < 4; l++) begin
      line(2'd0, (l == 1) ? 2 : 3, 64'h200 + 64'(l * 16));
      add_line((l == 1) ? 2 : 3, 64'h200 + 64'(l * 16));
    end
    vs_set(2'd0, 1'b0);
    verify("f2");
    meas("f2", 24, 4, 2);
    chk("f2_err_hres", 64'(err_hres), 64'd1);
    clear_errs;
    chk("f2_err_clr", 64'(err_hres), 64'd0);
    start_frame(2'd0);
    line(2'd0, 3, 64'h300);
    add_line(3, 64'h300);
    line(2'd0, 3, 64'h310);
    add_line(3, 64'h310);
    mipi_rx_HSYNC[0] = 1'b1;
    tick;
    beat(2'd0, DT_RGB888, 64'h320);
    add_line(1, 64'h320);
    mipi_rx_VSYNC[0] = 1'b0;
    tick;
    mipi_rx_HSYNC[0] = 1'b0;
    tick;
    tick;
    verify("f3");
    meas("f3", 24, 2, 3);
    chk("f3_err_trunc", 64'(err_trunc), 64'd1);
    chk("f3_err_hres", 64'(err_hres), 64'd0);
    clear_errs;
    cfg_vc = 2'd1;
    tick;
    tick;
    start_frame(2'd1);
    for (int l = 0; l < 2; l++) begin
      mipi_rx_HSYNC[1] = 1'b1;
      tick;
      for (int b = 0; b < 3; b++) begin
        beat(2'd1, DT_RGB888, 64'h400 + 64'(l * 16 + b));
        if (b < 2) beat(2'd0, DT_RAW8, 64'hdead);
      end
      mipi_rx_HSYNC[1] = 1'b0;
      tick;
      tick;
      add_line(3, 64'h400 + 64'(l * 16));
    end
    vs_set(2'd1, 1'b0);
    verify("f4");
    meas("f4", 24, 2, 4);
    chk("f4_err_type", 64'(err_type), 64'd0);
    start_frame(2'd1);
    mipi_rx_HSYNC[1] = 1'b1;
    tick;
    beat(2'd1, DT_RGB888, 64'h500);
    beat(2'd1, DT_RAW8, 64'hbad);
    beat(2'd1, DT_RGB888, 64'h501);
    beat(2'd1, DT_RGB888, 64'h502);
    mipi_rx_HSYNC[1] = 1'b0;
    tick;
    tick;
    add_line(3, 64'h500);
    vs_set(2'd1, 1'b0);
    verify("f5");
    meas("f5", 24, 1, 5);
    chk("f5_err_type", 64'(err_type), 64'd1);
    clear_errs;
    cfg_vc = 2'd0;
    tick;
    tick;
    start_frame(2'd0);
    mipi_rx_HSYNC[0] = 1'b1;
    tick;
    beat(2'd0, DT_RGB888, 64'h600);
    beat(2'd0, DT_RGB888, 64'h601);
    mipi_rx_HSYNC[0] = 1'b0;
    beat(2'd0, DT_RGB888, 64'h602);
    tick;
    tick;
    add_line(3, 64'h600);
    line(2'd0, 3, 64'h610);
    add_line(3, 64'h610);
    vs_set(2'd0, 1'b0);
    verify("f6");
    meas("f6", 24, 2, 6);
    chk("f6_errs", {err_hres, err_trunc, err_type}, 64'd0);
    vs_set(2'd0, 1'b1);
    mipi_rx_HSYNC[0] = 1'b1;
    tick;
    beat(2'd0, DT_RGB888, 64'h700);
    beat(2'd0, DT_RGB888, 64'h701);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {pix_data[31:0], pix_cnt, pix_valid, pix_sof, pix_eol, meas_valid,
                      err_hres, err_trunc, err_type}, 64'd0);
    chk("arst_meas", {meas_hres, meas_vres, frame_count}, 64'd0);
    mipi_rx_HSYNC = '0;
    mipi_rx_VSYNC = '0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    start_frame(2'd0);
    line(2'd0, 3, 64'h800);
    add_line(3, 64'h800);
    line(2'd0, 3, 64'h810);
    add_line(3, 64'h810);
    vs_set(2'd0, 1'b0);
    verify("f7");
    meas("f7", 24, 2, 1);
    chk("f7_errs", {err_hres, err_trunc, err_type}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
